// File: rtl/life_gen_ctrl.sv
// Game-of-Life generation sequencer over a ping-pong row RAM.
// Source rows stream through a 3-row window; one life_sum lane per column builds each new row.
module life_sum (
  input  logic       c,
  input  logic [7:0] nb,
  output logic       nxt
);
  logic [3:0] n;
  always_comb begin
    n = '0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, nb[k]};
    nxt = (n == 4'd3) | (c & (n == 4'd2));
  end
endmodule

module life_gen_ctrl #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int TORUS = 1,
  parameter int GENW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic            tick,
  output logic            rd_en,
  output logic [LOG2Y:0]  rd_addr,
  input  logic [X-1:0]    rd_data,
  output logic            wr_en,
  output logic [LOG2Y:0]  wr_addr,
  output logic [X-1:0]    wr_data,
  output logic            src_bank,
  output logic            busy,
  output logic            done,
  output logic [GENW-1:0] gen_count
);
  localparam int CW = LOG2Y + 2;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [LOG2Y-1:0]   rrow, wrow;
  logic [2:0]         vld_pipe;
  logic [X-1:0]       prev_row, cur_row, up_row, dn_row, nxt_row;
  logic [X-1:0][7:0]  nb;
  logic               wr_go;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start | (run & tick)) state_nxt = FETCH;
      FETCH: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (cnt == CW'(Y + 1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read k (0-based) fetches row k-1 mod Y: one halo row above, Y rows, one halo row below.
  always_comb begin
    int r;
    r = int'(cnt) - 1;
    if (r < 0)       r = Y - 1;
    else if (r >= Y) r = r - Y;
    rrow = LOG2Y'(r);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      wrow      <= '0;
      vld_pipe  <= '0;
      prev_row  <= '0;
      cur_row   <= '0;
      src_bank  <= 1'b0;
      gen_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], rd_en};
      if (state == IDLE)       cnt <= '0;
      else if (state == FETCH) cnt <= cnt + CW'(1);
      if (state == IDLE)       wrow <= '0;
      else if (wr_go)          wrow <= wrow + LOG2Y'(1);
      if (vld_pipe[0]) begin
        prev_row <= cur_row;
        cur_row  <= rd_data;
      end
      if (state == FLUSH) begin
        src_bank  <= ~src_bank;
        gen_count <= gen_count + GENW'(1);
      end
    end

  // A row is ready once three consecutive reads have landed: prev, cur in regs, next on rd_data.
  assign wr_go = busy & (&vld_pipe);

  assign up_row = (TORUS == 0 && wrow == '0) ? '0 : prev_row;
  assign dn_row = (TORUS == 0 && wrow == LOG2Y'(Y - 1)) ? '0 : rd_data;

  for (genvar i = 0; i < X; i++) begin : g_lane
    localparam logic [LOG2X-1:0] IL = LOG2X'((i + X - 1) % X);
    localparam logic [LOG2X-1:0] IR = LOG2X'((i + 1) % X);
    localparam logic EL = (TORUS != 0) || (i > 0);
    localparam logic ER = (TORUS != 0) || (i < X - 1);
    assign nb[i] = {up_row[IL] & EL, up_row[i], up_row[IR] & ER,
                    cur_row[IL] & EL,           cur_row[IR] & ER,
                    dn_row[IL] & EL, dn_row[i], dn_row[IR] & ER};
  end

  life_sum u_sum [X-1:0] (.c(cur_row), .nb(nb), .nxt(nxt_row));

  assign wr_en   = wr_go;
  assign rd_addr = rd_en ? {src_bank, rrow} : '0;
  assign wr_addr = wr_go ? {~src_bank, wrow} : '0;
  assign wr_data = wr_go ? nxt_row : '0;
endmodule

// File: tb/tb_life_gen_ctrl.sv
// Bench for life_gen_ctrl: a TORUS=1 and a TORUS=0 instance driven in lockstep,
// each with its own RAM, against a board-level life model and a cycle-offset timeline.
module tb_life_gen_ctrl;
  localparam int X = 8, Y = 8, LOG2Y = 3;
  typedef logic [Y-1:0][X-1:0] board_t;

  logic clk = 1'b0, rst_n, start, run, tick;
  logic            rd_en [2], wr_en [2], src_bank [2], busy [2], done [2];
  logic [LOG2Y:0]  rd_addr [2], wr_addr [2];
  logic [X-1:0]    rd_data [2], wr_data [2];
  logic [15:0]     gen_count [2];

  always #5 clk = ~clk;

  life_gen_ctrl #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(LOG2Y), .TORUS(1), .GENW(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(start), .run(run), .tick(tick),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .src_bank(src_bank[0]), .busy(busy[0]), .done(done[0]), .gen_count(gen_count[0]));

  life_gen_ctrl #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(LOG2Y), .TORUS(0), .GENW(16)) dut_p (
    .clk(clk), .rst_n(rst_n), .start(start), .run(run), .tick(tick),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .src_bank(src_bank[1]), .busy(busy[1]), .done(done[1]), .gen_count(gen_count[1]));

  int checks = 0, failures = 0, ndone = 0;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  function automatic board_t life_next(input board_t b, input bit torus);
    board_t o;
    o = '0;
    for (int r = 0; r < Y; r++)
      for (int c = 0; c < X; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0)) begin
              if (torus) n += int'(b[(rr + Y) % Y][(cc + X) % X]);
              else if (rr >= 0 && rr < Y && cc >= 0 && cc < X) n += int'(b[rr][cc]);
            end
          end
        o[r][c] = (n == 3) || (b[r][c] && n == 2);
      end
    return o;
  endfunction

  // Board RAMs plus the model: ph is the cycle offset since the accepted trigger (-1 = idle).
  logic [X-1:0] mem [2][2*Y];
  board_t       mboard [2], mnext [2], ld_board;
  logic         msrc [2];
  logic [15:0]  mgc [2];
  logic         ld_req = 1'b0;
  int           ph;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= -1;
      for (int d = 0; d < 2; d++) begin
        msrc[d] <= 1'b0;
        mgc[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d]) rd_data[d] <= mem[d][rd_addr[d]];
        if (wr_en[d]) mem[d][wr_addr[d]] <= wr_data[d];
        if (ld_req) begin
          mboard[d] <= ld_board;
          for (int r = 0; r < Y; r++) mem[d][(int'(msrc[d]) << LOG2Y) + r] <= ld_board[r];
        end
      end
      if (ph < 0) begin
        if (start | (run & tick)) begin
          ph <= 1;
          for (int d = 0; d < 2; d++) mnext[d] <= life_next(mboard[d], d == 0);
        end
      end else if (ph == Y + 3) begin
        ph <= Y + 4;
        for (int d = 0; d < 2; d++) begin
          mboard[d] <= mnext[d];
          msrc[d]   <= ~msrc[d];
          mgc[d]    <= mgc[d] + 16'd1;
        end
      end else if (ph == Y + 4) ph <= -1;
      else ph <= ph + 1;
    end
  end

  always @(negedge clk) if (rst_n) begin
    for (int d = 0; d < 2; d++) begin
      chk("rd_en", d, rd_en[d], ph >= 1 && ph <= Y + 2);
      if (ph >= 1 && ph <= Y + 2)
        chk("rd_addr", d, rd_addr[d], (int'(msrc[d]) << LOG2Y) + ((ph - 2 + Y) % Y));
      chk("wr_en", d, wr_en[d], ph >= 4 && ph <= Y + 3);
      if (ph >= 4 && ph <= Y + 3) begin
        chk("wr_addr", d, wr_addr[d], (int'(!msrc[d]) << LOG2Y) + (ph - 4));
        chk("wr_data", d, wr_data[d], mnext[d][ph - 4]);
      end
      chk("busy", d, busy[d], ph >= 1 && ph <= Y + 3);
      chk("done", d, done[d], ph == Y + 4);
      chk("src_bank", d, src_bank[d], msrc[d]);
      chk("gen_count", d, gen_count[d], mgc[d]);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic stepc();
    @(negedge clk); ndone += int'(done[0]);
    @(posedge clk); #1;
  endtask

  task automatic load(input board_t b);
    ld_board = b; ld_req = 1'b1;
    step();
    ld_req = 1'b0;
  endtask

  task automatic drain();
    start = 1'b0; tick = 1'b0; run = 1'b0;
    repeat (Y + 6) step();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    bit seen;
    seen = 1'b0;
    n = 1;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done[0]) seen = 1'b1;
      else begin step(); n++; end
    end
    if (!seen) chk("done_timeout", 0, 0, 1);
    step();
  endtask

  task automatic chk_zero(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_rd_en"}, d, rd_en[d], 0);
      chk({nm, "_rd_addr"}, d, rd_addr[d], 0);
      chk({nm, "_wr_en"}, d, wr_en[d], 0);
      chk({nm, "_wr_addr"}, d, wr_addr[d], 0);
      chk({nm, "_wr_data"}, d, wr_data[d], 0);
      chk({nm, "_src_bank"}, d, src_bank[d], 0);
      chk({nm, "_busy"}, d, busy[d], 0);
      chk({nm, "_done"}, d, done[d], 0);
      chk({nm, "_gen_count"}, d, gen_count[d], 0);
    end
  endtask

  task automatic chk_bank(input string nm, input int d, input board_t exp);
    for (int r = 0; r < Y; r++)
      chk(nm, d, mem[d][(int'(msrc[d]) << LOG2Y) + r], exp[r]);
  endtask

  board_t blinker, vert, wrap0, wrap_t, zero_b, rb;
  int lat;

  initial begin
    blinker = '0; blinker[3] = 8'h1C;
    vert = '0; vert[2] = 8'h08; vert[3] = 8'h08; vert[4] = 8'h08;
    wrap0 = '0; wrap0[0] = 8'h83;
    wrap_t = '0; wrap_t[7] = 8'h01; wrap_t[0] = 8'h01; wrap_t[1] = 8'h01;
    zero_b = '0;
    start = 1'b0; run = 1'b0; tick = 1'b0; rst_n = 1'b0;
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    chk("pin_blinker", 0, life_next(blinker, 1'b1), vert);
    chk("pin_wrap_torus", 0, life_next(wrap0, 1'b1), wrap_t);
    chk("pin_wrap_flat", 1, life_next(wrap0, 1'b0), zero_b);

    // Blinker and latency
    load(blinker);
    pulse_start();
    wait_done(lat);
    chk("latency", 0, lat, 12);
    for (int d = 0; d < 2; d++) begin
      chk_bank("blinker_bank1", d, vert);
      chk("blinker_src", d, src_bank[d], 1);
      chk("blinker_gen", d, gen_count[d], 1);
    end

    // Column/row wrap
    load(wrap0);
    pulse_start();
    wait_done(lat);
    chk_bank("wrap_torus", 0, wrap_t);
    chk_bank("wrap_flat", 1, zero_b);

    // Start during a generation is dropped
    load(blinker);
    ndone = 0;
    pulse_start();
    repeat (4) stepc();
    start = 1'b1; stepc(); start = 1'b0;
    repeat (20) stepc();
    chk("ignore_done_pulses", 0, ndone, 1);
    chk("ignore_gen", 0, gen_count[0], 3);

    // Free-run paced by tick
    ndone = 0;
    run = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick = 1'b1; stepc(); tick = 1'b0;
      repeat (19) stepc();
    end
    run = 1'b0;
    chk("run_done_pulses", 0, ndone, 4);
    chk("run_gen", 1, gen_count[1], 7);
    for (int d = 0; d < 2; d++) chk_bank("run_board", d, vert);

    // Async reset mid-generation, then a clean generation from bank0
    drain();
    load(blinker);
    pulse_start();
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    load(blinker);
    pulse_start();
    wait_done(lat);
    chk("reset_latency", 0, lat, 12);
    for (int d = 0; d < 2; d++) begin
      chk_bank("after_reset_bank1", d, vert);
      chk("after_reset_gen", d, gen_count[d], 1);
    end

    // Randomized boards and trigger traffic
    for (int p = 0; p < 5; p++) begin
      drain();
      rb = {$urandom, $urandom} & {$urandom, $urandom};
      load(rb);
      for (int c = 0; c < 250; c++) begin
        start = ($urandom % 10) == 0;
        tick  = ($urandom % 5) == 0;
        if (($urandom % 30) == 0) run = ~run;
        step();
      end
      drain();
      for (int d = 0; d < 2; d++) chk_bank("random_bank", d, mboard[d]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
